// File: rtl/plumbing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plumbing_pkg : arbiter state encoding, requester ids, pick function  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package plumbing_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_A = 2'd1,
        ARB_OWN_B = 2'd2
    } arb_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // A lone requester always wins; a tie goes to whoever holds priority.
    function automatic arb_state_e arb_pick(input logic a_v, input logic b_v, input logic prio);
        arb_state_e res;
        res = ARB_IDLE;
        if (a_v && !b_v) begin
            res = ARB_OWN_A;
        end else if (b_v && !a_v) begin
            res = ARB_OWN_B;
        end else if (a_v && b_v) begin
            res = (prio == REQ_B) ? ARB_OWN_B : ARB_OWN_A;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/selector_arbiter_selector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | selector : two-input WIDTH-bit mux, i_a when i_s=0, i_b when i_s=1   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module selector #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_s,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_s ? i_b : i_a;

endmodule
`default_nettype wire

// File: rtl/selector_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | selector_arbiter : per-packet round-robin arbiter, two valid/ready   |
// | producers onto one consumer, optional burst cap.  Revision : 1.0     |
// +----------------------------------------------------------------------+
module selector_arbiter
    import plumbing_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int MAX_BURST = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_a_valid,
    input  logic [BUS_WIDTH-1:0] i_a_data,
    input  logic                 i_a_last,
    output logic                 o_a_ready,
    input  logic                 i_b_valid,
    input  logic [BUS_WIDTH-1:0] i_b_data,
    input  logic                 i_b_last,
    output logic                 o_b_ready,
    output logic                 o_valid,
    output logic [BUS_WIDTH-1:0] o_data,
    output logic                 o_last,
    input  logic                 i_ready,
    output logic                 o_sel,
    output logic                 o_busy,
    output logic                 o_cut
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH:0]   CAP_LIMIT = (CNT_WIDTH+1)'(MAX_BURST);
    localparam logic [CNT_WIDTH:0]   CNT_ONE   = (CNT_WIDTH+1)'(1);

    arb_state_e           state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 prio_q, prio_d;
    logic                 cut_q, cut_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [BUS_WIDTH:0]   w_sel_y;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic                 w_own_valid;
    logic                 w_a_rdy;
    logic                 w_b_rdy;
    logic                 w_xfer;
    logic                 w_cap_hit;

    selector #(
        .WIDTH (BUS_WIDTH + 1)
    ) u_selector (
        .i_a (({i_a_last, i_a_data})),
        .i_b (({i_b_last, i_b_data})),
        .i_s (sel_q),
        .o_y (w_sel_y)
    );

    assign w_cnt_inc = {1'b0, cnt_q} + CNT_ONE;
    assign w_cap_hit = (MAX_BURST != 0) && (w_cnt_inc == CAP_LIMIT);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        cut_d       = 1'b0;
        w_own_valid = 1'b0;
        w_a_rdy     = 1'b0;
        w_b_rdy     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                state_d = arb_pick(i_a_valid, i_b_valid, prio_q);
                cnt_d   = '0;
            end
            ARB_OWN_A: begin
                w_own_valid = i_a_valid;
                w_a_rdy     = i_ready;
            end
            ARB_OWN_B: begin
                w_own_valid = i_b_valid;
                w_b_rdy     = i_ready;
            end
            default: state_d = ARB_IDLE;
        endcase

        // sel_q already points at the owner, so the selector's last bit is the owner's last.
        w_xfer = w_own_valid & i_ready;
        if (w_xfer) begin
            if (w_sel_y[BUS_WIDTH] || w_cap_hit) begin
                prio_d  = (state_q == ARB_OWN_A) ? REQ_B : REQ_A;
                state_d = arb_pick(i_a_valid, i_b_valid, prio_d);
                cnt_d   = '0;
                cut_d   = w_cap_hit & ~w_sel_y[BUS_WIDTH];
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = w_cnt_inc[CNT_WIDTH-1:0];
            end
        end

        if (state_d == ARB_OWN_A) begin
            sel_d = REQ_A;
        end else if (state_d == ARB_OWN_B) begin
            sel_d = REQ_B;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            sel_q   <= REQ_A;
            prio_q  <= REQ_A;
            cnt_q   <= '0;
            cut_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            cut_q   <= cut_d;
        end
    end

    assign o_valid   = w_own_valid & ~i_rst;
    assign o_a_ready = w_a_rdy & ~i_rst;
    assign o_b_ready = w_b_rdy & ~i_rst;
    assign o_data    = w_sel_y[BUS_WIDTH-1:0];
    assign o_last    = w_sel_y[BUS_WIDTH];
    assign o_sel     = sel_q;
    assign o_busy    = (state_q != ARB_IDLE);
    assign o_cut     = cut_q;

endmodule
`default_nettype wire

// File: tb/tb_selector_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_selector_arbiter : two DUTs (uncapped, cap=4) against a packet-   |
// | level reference model, directed packets plus random traffic. Rev 1.0 |
// +----------------------------------------------------------------------+
module tb_selector_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0, rdy = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;

    logic [1:0] ov, oar, obr, olast, osel, obusy, ocut;
    logic [7:0] od [2];

    always #5 clk = ~clk;

    selector_arbiter #(.BUS_WIDTH(8), .MAX_BURST(0), .CNT_WIDTH(8)) u_dut_u (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_data(a_data), .i_a_last(a_last), .o_a_ready(oar[0]),
        .i_b_valid(b_valid), .i_b_data(b_data), .i_b_last(b_last), .o_b_ready(obr[0]),
        .o_valid(ov[0]), .o_data(od[0]), .o_last(olast[0]), .i_ready(rdy),
        .o_sel(osel[0]), .o_busy(obusy[0]), .o_cut(ocut[0])
    );

    selector_arbiter #(.BUS_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(8)) u_dut_c (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_data(a_data), .i_a_last(a_last), .o_a_ready(oar[1]),
        .i_b_valid(b_valid), .i_b_data(b_data), .i_b_last(b_last), .o_b_ready(obr[1]),
        .o_valid(ov[1]), .o_data(od[1]), .o_last(olast[1]), .i_ready(rdy),
        .o_sel(osel[1]), .o_busy(obusy[1]), .o_cut(ocut[1])
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s [dut%0d] t=%0t got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, prio 0=A 1=B, beats taken in current grant.
    localparam int MB [2] = '{0, 4};
    int m_owner [2] = '{0, 0};
    int m_sel   [2] = '{0, 0};
    int m_prio  [2] = '{0, 0};
    int m_cnt   [2] = '{0, 0};
    int m_cut   [2] = '{0, 0};

    function automatic int pick(input bit av, input bit bv, input int pr);
        if (av && bv) return (pr == 1) ? 2 : 1;
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit ev, ear, ebr, lst, capr;
        for (int k = 0; k < 2; k++) begin
            ev  = !rst && ((m_owner[k] == 1 && a_valid) || (m_owner[k] == 2 && b_valid));
            ear = !rst && m_owner[k] == 1 && rdy;
            ebr = !rst && m_owner[k] == 2 && rdy;
            if (chk_en) begin
                chk("o_valid",   k, 32'(ov[k]),    32'(ev));
                chk("o_a_ready", k, 32'(oar[k]),   32'(ear));
                chk("o_b_ready", k, 32'(obr[k]),   32'(ebr));
                chk("o_data",    k, 32'(od[k]),    32'(m_sel[k] == 1 ? b_data : a_data));
                chk("o_last",    k, 32'(olast[k]), 32'(m_sel[k] == 1 ? b_last : a_last));
                chk("o_sel",     k, 32'(osel[k]),  32'(m_sel[k]));
                chk("o_busy",    k, 32'(obusy[k]), 32'(m_owner[k] != 0));
                chk("o_cut",     k, 32'(ocut[k]),  32'(m_cut[k]));
            end
            if (rst) begin
                m_owner[k] = 0; m_sel[k] = 0; m_prio[k] = 0; m_cnt[k] = 0; m_cut[k] = 0;
            end else if (m_owner[k] == 0) begin
                m_owner[k] = pick(a_valid, b_valid, m_prio[k]);
                if (m_owner[k] != 0) m_sel[k] = (m_owner[k] == 2) ? 1 : 0;
                m_cnt[k] = 0;
                m_cut[k] = 0;
            end else begin
                m_cut[k] = 0;
                if (ev && rdy) begin
                    lst  = (m_owner[k] == 1) ? a_last : b_last;
                    capr = (MB[k] != 0) && (m_cnt[k] + 1 == MB[k]);
                    if (lst || capr) begin
                        m_prio[k]  = (m_owner[k] == 1) ? 1 : 0;
                        m_cut[k]   = (capr && !lst) ? 1 : 0;
                        m_owner[k] = pick(a_valid, b_valid, m_prio[k]);
                        if (m_owner[k] != 0) m_sel[k] = (m_owner[k] == 2) ? 1 : 0;
                        m_cnt[k]   = 0;
                    end else begin
                        m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
                    end
                end
            end
        end
    end

    // Directed packet producer follows the capped DUT's handshakes and logs its output beats.
    logic [8:0] qa [$];
    logic [8:0] qb [$];
    logic [8:0] out_q [$];
    int         stamp_q [$];
    int         cuts;

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_pkts(input int a_start, input int stall, input logic [7:0] stall_data);
        int c;
        bit af, bf;
        c = 0;
        out_q.delete(); stamp_q.delete(); cuts = 0;
        while ((qa.size() != 0 || qb.size() != 0) && c < 200) begin
            a_valid = (qa.size() != 0) && (c >= a_start);
            b_valid = (qb.size() != 0);
            if (qa.size() != 0) begin a_data = qa[0][7:0]; a_last = qa[0][8]; end
            if (qb.size() != 0) begin b_data = qb[0][7:0]; b_last = qb[0][8]; end
            rdy = (c > stall);
            @(negedge clk);
            if (c >= 1 && c <= stall) begin
                chk("stall_a_ready", 1, 32'(oar[1]), 32'd0);
                chk("stall_b_ready", 1, 32'(obr[1]), 32'd0);
                chk("stall_data",    1, 32'(od[1]),  32'(stall_data));
                chk("stall_sel",     1, 32'(osel[1]), 32'd0);
            end
            af = a_valid && oar[1];
            bf = b_valid && obr[1];
            if (ov[1] && rdy) begin
                out_q.push_back({olast[1], od[1]});
                stamp_q.push_back(c);
            end
            if (ocut[1]) cuts++;
            @(posedge clk);
            #1;
            if (af) void'(qa.pop_front());
            if (bf) void'(qb.pop_front());
            c++;
        end
        if (c >= 200) begin
            n_vec++; n_err++;
            $display("FAIL pkt_timeout: producer queues not drained after %0d cycles", c);
        end
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        @(negedge clk);
        if (ocut[1]) cuts++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_seq(input string nm, input logic [8:0] exp [$]);
        chk({nm, "_len"}, 1, 32'(out_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_q.size(); i++)
            chk(nm, 1, 32'(out_q[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [8:0] e [$];
        @(posedge clk);
        chk_en = 1'b1;
        #1;

        // single A packet
        do_reset();
        qa = '{9'h011, 9'h012, 9'h113};
        run_pkts(0, 0, 8'h00);
        e = '{9'h011, 9'h012, 9'h113};
        chk_seq("t1_seq", e);

        // A and B tie: A first, B follows with no gap
        do_reset();
        qa = '{9'h021, 9'h122};
        qb = '{9'h031, 9'h132};
        run_pkts(0, 0, 8'h00);
        e = '{9'h021, 9'h122, 9'h031, 9'h132};
        chk_seq("t2_seq", e);
        if (stamp_q.size() >= 3) chk("t2_gap", 1, 32'(stamp_q[2] - stamp_q[1]), 32'd1);

        // burst cap on B, A slips in between
        do_reset();
        qb = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h045, 9'h146};
        qa = '{9'h151};
        run_pkts(2, 0, 8'h00);
        e = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h151, 9'h045, 9'h146};
        chk_seq("t3_seq", e);
        chk("t3_cuts", 1, 32'(cuts), 32'd1);

        // owner stall with B waiting
        do_reset();
        qa = '{9'h071, 9'h172};
        qb = '{9'h181};
        run_pkts(0, 5, 8'h71);
        e = '{9'h071, 9'h172, 9'h181};
        chk_seq("t4_seq", e);

        // A alone, back-to-back one-beat packets
        do_reset();
        qa = '{9'h161, 9'h162};
        run_pkts(0, 0, 8'h00);
        e = '{9'h161, 9'h162};
        chk_seq("t5_seq", e);
        if (stamp_q.size() >= 2) chk("t5_gap", 1, 32'(stamp_q[1] - stamp_q[0]), 32'd1);

        // reset in the middle of a B packet
        do_reset();
        b_valid = 1'b1; b_data = 8'h91; b_last = 1'b0; rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_busy_b", 1, 32'(obusy[1]), 32'd1);
        chk("t6_sel_b",  1, 32'(osel[1]),  32'd1);
        @(posedge clk); #1;
        b_data = 8'h92; rst = 1'b1;
        @(negedge clk);
        chk("t6_valid_in_rst", 1, 32'(ov[1]),  32'd0);
        chk("t6_bready_in_rst", 1, 32'(obr[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy_after", 1, 32'(obusy[1]), 32'd0);
        chk("t6_sel_after",  1, 32'(osel[1]),  32'd0);
        chk("t6_valid_after", 1, 32'(ov[1]),   32'd0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 8'hA1; b_valid = 1'b1; b_data = 8'hB1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_prio_a_sel",  1, 32'(osel[1]), 32'd0);
        chk("t6_prio_a_data", 1, 32'(od[1]),   32'h0A1);
        @(posedge clk); #1;

        // random traffic, occasional resets
        repeat (3000) begin
            rst     = ($urandom_range(0, 99) == 0);
            a_valid = ($urandom_range(0, 9) < 7);
            b_valid = ($urandom_range(0, 9) < 7);
            a_last  = ($urandom_range(0, 3) == 0);
            b_last  = ($urandom_range(0, 3) == 0);
            rdy     = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
